// File: rtl/serial_pkg.sv
// serial_pkg
//  Shared types for the serial stimulus blocks (TX today, RX later).
//  parity_e   : parity mode selected by a block parameter
//  tx_state_e : transmitter frame sequencer states
package serial_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/serial_stimulus_tx_if.sv
// serial_stimulus_tx_if
//  Byte write handshake into the transmitter FIFO.
//  WrData  : byte to queue (DATA_BITS wide)
//  WrValid : push request from the producer
//  WrReady : FIFO has room; a push happens when WrValid && WrReady
//  master = producer side, slave = transmitter side.
interface serial_stimulus_tx_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] WrData;
  logic                 WrValid;
  logic                 WrReady;

  modport master (output WrData, output WrValid, input WrReady);
  modport slave  (input WrData, input WrValid, output WrReady);

endinterface

// File: rtl/serial_fifo.sv
// serial_fifo
//  Small synchronous FIFO with an occupancy counter, shared by the serial TX/RX blocks.
//  Clock      : rising-edge clock
//  Reset      : synchronous active-low reset, empties the FIFO
//  push_i     : write request, ignored while full
//  pushData_i : write data
//  pop_i      : read request, ignored while empty
//  popData_o  : head entry (valid while not empty)
//  full_o     : no free entry
//  empty_o    : no stored entry
//  level_o    : current number of stored entries
module serial_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         pushData_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         popData_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q;
  logic [AW-1:0]    rdPtr_q;
  logic [LW-1:0]    level_q;
  logic [LW-1:0]    level_d;
  logic             doPush;
  logic             doPop;

  // Full/empty come straight from the registered level, so a pop never
  // opens a slot for a push in the same cycle.
  assign full_o    = (level_q == LW'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign popData_o = mem_q[rdPtr_q];
  assign doPush    = push_i && !full_o;
  assign doPop     = pop_i && !empty_o;

  // Occupancy only moves when exactly one of push/pop takes effect.
  always_comb begin
    level_d = level_q;
    if (doPush && !doPop) begin
      level_d = level_q + 1'b1;
    end else if (!doPush && doPop) begin
      level_d = level_q - 1'b1;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      level_q <= level_d;
    end
  end

  // Storage needs no reset; stale entries are never visible past level.
  always_ff @(posedge Clock) begin
    if (doPush) mem_q[wrPtr_q] <= pushData_i;
  end

endmodule

// File: rtl/serial_stimulus_tx.sv
// serial_stimulus_tx
//  UART-style byte transmitter fed from a small FIFO. Frame = start bit, DATA_BITS
//  data bits LSB first, optional parity bit, STOP_BITS stop bits.
//  Clock     : rising-edge clock
//  Reset     : synchronous active-low reset, aborts any frame at once
//  BaudDiv   : clocks per bit minus one, captured at the start of each frame
//  wr        : byte push handshake (WrData/WrValid/WrReady)
//  Txd       : registered serial line, idles high
//  Busy      : frame in progress or bytes still queued
//  Level     : FIFO occupancy
//  FrameDone : one-cycle pulse right after the last stop bit
module serial_stimulus_tx
  import serial_pkg::*;
#(
  parameter int      DATA_BITS  = 8,
  parameter parity_e PARITY     = PAR_NONE,
  parameter int      STOP_BITS  = 1,
  parameter int      FIFO_DEPTH = 8,
  parameter int      DIV_W      = 16
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic [DIV_W-1:0]              BaudDiv,
  serial_stimulus_tx_if.slave           wr,
  output logic                          Txd,
  output logic                          Busy,
  output logic [$clog2(FIFO_DEPTH):0]   Level,
  output logic                          FrameDone
);

  tx_state_e            state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DIV_W-1:0]     baudCnt_q;
  logic [DIV_W-1:0]     baudDiv_q;
  logic [2:0]           bitCnt_q;
  logic                 parity_q;
  logic                 txd_q;
  logic                 frameDone_q;

  logic                 fifoFull;
  logic                 fifoEmpty;
  logic [DATA_BITS-1:0] fifoData;
  logic                 fifoPop;
  logic                 bitEnd;
  logic                 lastStop;

  serial_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .Clock      (Clock),
    .Reset      (Reset),
    .push_i     (wr.WrValid),
    .pushData_i (wr.WrData),
    .pop_i      (fifoPop),
    .popData_o  (fifoData),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty),
    .level_o    (Level)
  );

  assign wr.WrReady = !fifoFull;
  assign Txd        = txd_q;
  assign FrameDone  = frameDone_q;
  assign Busy       = (state_q != TX_IDLE) || (Level != '0);

  // A bit period ends when the baud counter reaches the divider latched
  // for this frame, so BaudDiv changes only take effect on the next frame.
  assign bitEnd   = (baudCnt_q == baudDiv_q);
  assign lastStop = (bitCnt_q == 3'(STOP_BITS - 1));

  // The head byte leaves the FIFO either from IDLE or on the final stop
  // clock, the latter giving back-to-back frames with no idle gap.
  assign fifoPop = !fifoEmpty &&
                   ((state_q == TX_IDLE) ||
                    ((state_q == TX_STOP) && bitEnd && lastStop));

  // Frame sequencer. Txd is always assigned the value of the bit that the
  // next cycle will carry, so the line comes straight from a flop.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q     <= TX_IDLE;
      shift_q     <= '0;
      baudCnt_q   <= '0;
      baudDiv_q   <= '0;
      bitCnt_q    <= '0;
      parity_q    <= 1'b0;
      txd_q       <= 1'b1;
      frameDone_q <= 1'b0;
    end else begin
      frameDone_q <= 1'b0;
      case (state_q)
        TX_IDLE: begin
          txd_q <= 1'b1;
          if (fifoPop) begin
            shift_q   <= fifoData;
            baudDiv_q <= BaudDiv;
            baudCnt_q <= '0;
            bitCnt_q  <= '0;
            parity_q  <= (PARITY == PAR_ODD);
            txd_q     <= 1'b0;
            state_q   <= TX_START;
          end
        end

        TX_START: begin
          if (bitEnd) begin
            baudCnt_q <= '0;
            txd_q     <= shift_q[0];
            state_q   <= TX_DATA;
          end else begin
            baudCnt_q <= baudCnt_q + 1'b1;
          end
        end

        // parity_q starts at 1 for odd parity so that folding every data
        // bit in yields the bit to send for either mode.
        TX_DATA: begin
          if (bitEnd) begin
            baudCnt_q <= '0;
            parity_q  <= parity_q ^ shift_q[0];
            shift_q   <= shift_q >> 1;
            if (bitCnt_q == 3'(DATA_BITS - 1)) begin
              bitCnt_q <= '0;
              if (PARITY != PAR_NONE) begin
                txd_q   <= parity_q ^ shift_q[0];
                state_q <= TX_PARITY;
              end else begin
                txd_q   <= 1'b1;
                state_q <= TX_STOP;
              end
            end else begin
              bitCnt_q <= bitCnt_q + 1'b1;
              txd_q    <= shift_q[1];
            end
          end else begin
            baudCnt_q <= baudCnt_q + 1'b1;
          end
        end

        TX_PARITY: begin
          if (bitEnd) begin
            baudCnt_q <= '0;
            txd_q     <= 1'b1;
            state_q   <= TX_STOP;
          end else begin
            baudCnt_q <= baudCnt_q + 1'b1;
          end
        end

        TX_STOP: begin
          if (bitEnd) begin
            baudCnt_q <= '0;
            if (lastStop) begin
              frameDone_q <= 1'b1;
              bitCnt_q    <= '0;
              if (fifoPop) begin
                shift_q   <= fifoData;
                baudDiv_q <= BaudDiv;
                parity_q  <= (PARITY == PAR_ODD);
                txd_q     <= 1'b0;
                state_q   <= TX_START;
              end else begin
                txd_q   <= 1'b1;
                state_q <= TX_IDLE;
              end
            end else begin
              bitCnt_q <= bitCnt_q + 1'b1;
            end
          end else begin
            baudCnt_q <= baudCnt_q + 1'b1;
          end
        end

        default: begin
          txd_q   <= 1'b1;
          state_q <= TX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_stimulus_tx.sv
// tb_serial_stimulus_tx
//  Three transmitters (8N1, 7E2, 7O2) share clock and reset. Stimulus queues the
//  expected serial bit pattern of each byte it pushes; a monitor walks Txd of every
//  channel clock by clock against the head of its queue and checks FrameDone and
//  back-to-back framing.
module tb_serial_stimulus_tx;
  import serial_pkg::*;

  typedef struct {
    logic [15:0] bits;
    int          nBits;
    int          div;
    bit          contig;
    logic [7:0]  data;
  } exp_t;

  logic        clk;
  logic        rstN;
  logic [15:0] baud0, baud1, baud2;
  logic        txd0, txd1, txd2;
  logic        busy0, busy1, busy2;
  logic [3:0]  level0, level1, level2;
  logic        fd0, fd1, fd2;

  int vectors = 0;
  int miscompares = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  exp_t cur[3];
  bit   active[3];
  bit   waitDone[3];
  int   bitIdx[3];
  int   clkCnt[3];
  int   frameErr[3];
  int   badBit[3];

  serial_stimulus_tx_if #(.DATA_BITS(8)) if0 ();
  serial_stimulus_tx_if #(.DATA_BITS(7)) if1 ();
  serial_stimulus_tx_if #(.DATA_BITS(7)) if2 ();

  serial_stimulus_tx #(.DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(8), .DIV_W(16)) dut0 (
    .Clock(clk), .Reset(rstN), .BaudDiv(baud0), .wr(if0),
    .Txd(txd0), .Busy(busy0), .Level(level0), .FrameDone(fd0));

  serial_stimulus_tx #(.DATA_BITS(7), .PARITY(PAR_EVEN), .STOP_BITS(2), .FIFO_DEPTH(8), .DIV_W(16)) dut1 (
    .Clock(clk), .Reset(rstN), .BaudDiv(baud1), .wr(if1),
    .Txd(txd1), .Busy(busy1), .Level(level1), .FrameDone(fd1));

  serial_stimulus_tx #(.DATA_BITS(7), .PARITY(PAR_ODD), .STOP_BITS(2), .FIFO_DEPTH(8), .DIV_W(16)) dut2 (
    .Clock(clk), .Reset(rstN), .BaudDiv(baud2), .wr(if2),
    .Txd(txd2), .Busy(busy2), .Level(level2), .FrameDone(fd2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Expected line pattern: start bit, data LSB first, optional parity, stop bits.
  function automatic exp_t mkFrame(input logic [7:0] d, input int nData, input int par,
                                   input int stops, input int div, input bit contig);
    exp_t e;
    int   idx;
    logic p;
    e.bits = '0;
    idx = 1;
    p = 1'b0;
    for (int i = 0; i < nData; i++) begin
      e.bits[idx] = d[i];
      p = p ^ d[i];
      idx++;
    end
    if (par == 1) begin e.bits[idx] = p;  idx++; end
    if (par == 2) begin e.bits[idx] = ~p; idx++; end
    for (int i = 0; i < stops; i++) begin
      e.bits[idx] = 1'b1;
      idx++;
    end
    e.nBits = idx;
    e.div = div;
    e.contig = contig;
    e.data = d;
    return e;
  endfunction

  function automatic exp_t mkLit(input logic [15:0] bits, input int n, input int div,
                                 input bit contig, input logic [7:0] d);
    exp_t e;
    e.bits = bits;
    e.nBits = n;
    e.div = div;
    e.contig = contig;
    e.data = d;
    return e;
  endfunction

  task automatic qPush(input int ch, input exp_t e);
    case (ch)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic qPop(input int ch, output exp_t e);
    case (ch)
      0: e = q0.pop_front();
      1: e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  function automatic int qSize(input int ch);
    case (ch)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  // One sample of one channel's line, taken on the falling clock edge.
  task automatic monStep(input int ch, input logic txd, input logic fd);
    bit   endedNow;
    exp_t e;
    endedNow = 1'b0;
    if (rstN !== 1'b1) begin
      active[ch] = 1'b0;
      waitDone[ch] = 1'b0;
      return;
    end
    if (waitDone[ch]) begin
      checkOutput($sformatf("framedone ch%0d data %02h", ch, cur[ch].data), 32'(fd), 32'd1);
      waitDone[ch] = 1'b0;
      endedNow = 1'b1;
    end else if (fd !== 1'b0) begin
      checkOutput($sformatf("stray framedone ch%0d", ch), 32'(fd), 32'd0);
    end
    if (!active[ch] && txd === 1'b0) begin
      if (qSize(ch) == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected frame ch%0d: got start bit, want idle line", ch);
        cur[ch] = mkLit(16'h0, 1, 0, 1'b0, 8'h00);
      end else begin
        qPop(ch, e);
        cur[ch] = e;
        checkOutput($sformatf("contiguous ch%0d data %02h", ch, e.data),
                    32'(endedNow), 32'(e.contig));
      end
      active[ch] = 1'b1;
      bitIdx[ch] = 0;
      clkCnt[ch] = 0;
      frameErr[ch] = 0;
      badBit[ch] = -1;
    end
    if (active[ch]) begin
      if (txd !== cur[ch].bits[bitIdx[ch]]) begin
        if (frameErr[ch] == 0) badBit[ch] = bitIdx[ch];
        frameErr[ch]++;
      end
      clkCnt[ch]++;
      if (clkCnt[ch] == cur[ch].div + 1) begin
        clkCnt[ch] = 0;
        bitIdx[ch]++;
        if (bitIdx[ch] == cur[ch].nBits) begin
          active[ch] = 1'b0;
          waitDone[ch] = 1'b1;
          vectors++;
          if (frameErr[ch] != 0) begin
            miscompares++;
            $display("[TB] FAIL frame ch%0d data %02h: got %0d wrong samples from bit %0d, want pattern %04h",
                     ch, cur[ch].data, frameErr[ch], badBit[ch], cur[ch].bits);
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    monStep(0, txd0, fd0);
    monStep(1, txd1, fd1);
    monStep(2, txd2, fd2);
  end

  // Drive one push for a single cycle; called on a falling edge.
  task automatic applyStimulus(input int ch, input logic [7:0] d);
    case (ch)
      0: begin if0.WrData = d;      if0.WrValid = 1'b1; end
      1: begin if1.WrData = d[6:0]; if1.WrValid = 1'b1; end
      default: begin if2.WrData = d[6:0]; if2.WrValid = 1'b1; end
    endcase
    @(negedge clk);
    if0.WrValid = 1'b0;
    if1.WrValid = 1'b0;
    if2.WrValid = 1'b0;
  endtask

  // Hold a push on channel 0 until the FIFO has room, as a producer would.
  task automatic pushReady(input logic [7:0] d, input int div);
    bit done;
    done = 1'b0;
    if0.WrData = d;
    if0.WrValid = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      if (if0.WrReady === 1'b1) begin
        done = 1'b1;
        qPush(0, mkFrame(d, 8, 0, 1, div, 1'b1));
      end
      @(negedge clk);
    end
    if0.WrValid = 1'b0;
    if (done) checkOutput($sformatf("level refill %02h", d), 32'(level0), 32'd8);
    else begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL push %02h: got WrReady low for 200 cycles, want a free slot", d);
    end
  endtask

  task automatic waitDrain(input int ch, input int budget);
    bit done;
    logic b;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge clk);
      b = (ch == 0) ? busy0 : (ch == 1) ? busy1 : busy2;
      if (b === 1'b0 && !active[ch] && !waitDone[ch] && qSize(ch) == 0) done = 1'b1;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain ch%0d: got still busy after %0d cycles, want idle", ch, budget);
    end
  endtask

  initial begin
    rstN = 1'b0;
    baud0 = 16'd3;
    baud1 = 16'd2;
    baud2 = 16'd2;
    if0.WrData = '0; if0.WrValid = 1'b0;
    if1.WrData = '0; if1.WrValid = 1'b0;
    if2.WrData = '0; if2.WrValid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      active[c] = 1'b0;
      waitDone[c] = 1'b0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset Txd", 32'(txd0), 32'd1);
    checkOutput("reset WrReady", 32'(if0.WrReady), 32'd1);
    checkOutput("reset Busy", 32'(busy0), 32'd0);
    checkOutput("reset Level", 32'(level0), 32'd0);
    checkOutput("reset FrameDone", 32'(fd0), 32'd0);
    rstN = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1, BaudDiv=3, 0x55: start 0, 1010_1010 LSB first, stop 1
    $display("[TB] 8N1 0x55 at 4 clocks per bit");
    qPush(0, mkLit(16'h02AA, 10, 3, 1'b0, 8'h55));
    applyStimulus(0, 8'h55);
    checkOutput("latency Txd still idle", 32'(txd0), 32'd1);
    checkOutput("latency Level one", 32'(level0), 32'd1);
    checkOutput("latency Busy", 32'(busy0), 32'd1);
    @(negedge clk);
    checkOutput("latency Txd falls", 32'(txd0), 32'd0);
    checkOutput("latency Level popped", 32'(level0), 32'd0);
    waitDrain(0, 200);
    checkOutput("Busy low after frame", 32'(busy0), 32'd0);
    checkOutput("Txd idle after frame", 32'(txd0), 32'd1);

    // 7E2 / 7O2 with 0x03: data 1100000, parity 0 (even) or 1 (odd)
    $display("[TB] 7E2 and 7O2 frames");
    qPush(1, mkLit(16'h0606, 11, 2, 1'b0, 8'h03));
    applyStimulus(1, 8'h03);
    qPush(2, mkLit(16'h0706, 11, 2, 1'b0, 8'h03));
    applyStimulus(2, 8'h03);
    qPush(2, mkFrame(8'h7F, 7, 2, 2, 2, 1'b1));
    applyStimulus(2, 8'h7F);
    waitDrain(1, 300);
    waitDrain(2, 300);

    // BaudDiv change mid-frame only affects the following frame
    $display("[TB] baud divider change 3 -> 1");
    baud0 = 16'd3;
    qPush(0, mkFrame(8'hC3, 8, 0, 1, 3, 1'b0));
    applyStimulus(0, 8'hC3);
    qPush(0, mkFrame(8'h3C, 8, 0, 1, 1, 1'b1));
    applyStimulus(0, 8'h3C);
    repeat (10) @(negedge clk);
    baud0 = 16'd1;
    waitDrain(0, 300);

    // Reset in the middle of a frame with bytes still queued
    $display("[TB] reset abort mid frame");
    baud0 = 16'd3;
    qPush(0, mkFrame(8'hA5, 8, 0, 1, 3, 1'b0));
    applyStimulus(0, 8'hA5);
    applyStimulus(0, 8'h11);
    applyStimulus(0, 8'h22);
    applyStimulus(0, 8'h33);
    checkOutput("queued before abort", 32'(level0), 32'd3);
    repeat (10) @(negedge clk);
    rstN = 1'b0;
    q0.delete();
    @(negedge clk);
    rstN = 1'b1;
    checkOutput("abort Txd", 32'(txd0), 32'd1);
    checkOutput("abort Level", 32'(level0), 32'd0);
    checkOutput("abort WrReady", 32'(if0.WrReady), 32'd1);
    checkOutput("abort Busy", 32'(busy0), 32'd0);
    checkOutput("abort FrameDone", 32'(fd0), 32'd0);
    repeat (50) @(negedge clk);
    qPush(0, mkFrame(8'h0F, 8, 0, 1, 3, 1'b0));
    applyStimulus(0, 8'h0F);
    waitDrain(0, 200);

    // Ten pushes on consecutive cycles: nine fit (one in the shifter,
    // eight queued), the tenth is refused while full.
    $display("[TB] FIFO fill, overflow and wrap");
    baud0 = 16'd1;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) checkOutput("push and pop level", 32'(level0), 32'd1);
      if (i == 9) begin
        checkOutput("level full", 32'(level0), 32'd8);
        checkOutput("WrReady full", 32'(if0.WrReady), 32'd0);
      end
      if0.WrData = 8'(8'hA0 + i * 7);
      if0.WrValid = 1'b1;
      if (i < 9) qPush(0, mkFrame(8'(8'hA0 + i * 7), 8, 0, 1, 1, i != 0));
      @(negedge clk);
    end
    if0.WrValid = 1'b0;
    checkOutput("overflow push ignored", 32'(level0), 32'd8);

    // Keep the FIFO topped up so the pointers wrap while frames stream out
    for (int j = 0; j < 12; j++) begin
      pushReady(8'(8'h30 + j * 13), 1);
    end
    waitDrain(0, 1000);

    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("leftover expectations ch%0d", c), 32'(qSize(c)), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
